// File: rtl/maze_grid_store.sv
// Maze map store: captures strobed radio packets into a COLS x ROWS grid of
// 2-bit cells, tracks robot position and explored-cell count, serves a registered read port.
module maze_grid_store #(
  parameter int COLS = 5,
  parameter int ROWS = 4
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       DATA_VALID,
  input  logic [2:0] RADIO_X,
  input  logic [1:0] RADIO_Y,
  input  logic [1:0] VALUE,
  input  logic       CLEAR,
  input  logic [2:0] READ_X,
  input  logic [1:0] READ_Y,
  output logic [1:0] READ_VALUE,
  output logic [2:0] ROBOT_X,
  output logic [1:0] ROBOT_Y,
  output logic [4:0] VISITED_COUNT,
  output logic       UPDATE,
  output logic       ERR_RANGE,
  output logic       ERR_DROP
);

  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {IDLE, LATCH, CHECK, WRITE} state_t;

  state_t     state;
  logic [1:0] cells [CELLS];
  logic       sync1, sync2, sync3;
  logic       strobe_edge;
  logic [2:0] cap_x;
  logic [1:0] cap_y;
  logic [1:0] cap_v;
  logic       cap_in_range;
  logic       rd_in_range;
  logic [4:0] wr_idx;
  logic [4:0] rd_idx;
  logic [1:0] old_val;

  function automatic logic [4:0] cell_index(input logic [2:0] x, input logic [1:0] y);
    return 5'(y) * 5'(COLS) + 5'(x);
  endfunction

  // The synchronizer is deliberately untouched by CLEAR so a held strobe is not re-detected.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= DATA_VALID;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign strobe_edge = sync2 & ~sync3;

  always_comb begin
    cap_in_range = (32'(cap_x) < COLS) && (32'(cap_y) < ROWS);
    rd_in_range  = (32'(READ_X) < COLS) && (32'(READ_Y) < ROWS);
    wr_idx       = cap_in_range ? cell_index(cap_x, cap_y) : '0;
    rd_idx       = rd_in_range ? cell_index(READ_X, READ_Y) : '0;
    old_val      = cells[wr_idx];
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state         <= IDLE;
      for (int unsigned i = 0; i < CELLS; i++) cells[i] <= '0;
      cap_x         <= '0;
      cap_y         <= '0;
      cap_v         <= '0;
      ROBOT_X       <= '0;
      ROBOT_Y       <= '0;
      VISITED_COUNT <= '0;
      UPDATE        <= 1'b0;
      ERR_RANGE     <= 1'b0;
      ERR_DROP      <= 1'b0;
    end else begin
      UPDATE <= 1'b0;
      if (CLEAR) begin
        for (int unsigned i = 0; i < CELLS; i++) cells[i] <= '0;
        ROBOT_X       <= '0;
        ROBOT_Y       <= '0;
        VISITED_COUNT <= '0;
        ERR_RANGE     <= 1'b0;
        ERR_DROP      <= 1'b0;
        state         <= IDLE;
      end else begin
        if (strobe_edge && state != IDLE) ERR_DROP <= 1'b1;
        case (state)
          IDLE: if (strobe_edge) state <= LATCH;
          LATCH: begin
            cap_x <= RADIO_X;
            cap_y <= RADIO_Y;
            cap_v <= VALUE;
            state <= CHECK;
          end
          CHECK: begin
            if (!cap_in_range) begin
              ERR_RANGE <= 1'b1;
              state     <= IDLE;
            end else if (cap_v == 2'b00) begin
              state <= IDLE;
            end else begin
              state <= WRITE;
            end
          end
          WRITE: begin
            cells[wr_idx] <= cap_v;
            ROBOT_X       <= cap_x;
            ROBOT_Y       <= cap_y;
            if (old_val != cap_v) UPDATE <= 1'b1;
            if (old_val == 2'b00 && VISITED_COUNT < 5'(CELLS))
              VISITED_COUNT <= VISITED_COUNT + 5'd1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) READ_VALUE <= '0;
    else        READ_VALUE <= rd_in_range ? cells[rd_idx] : '0;
  end

endmodule

// File: tb/tb_maze_grid_store.sv
// Self-checking bench for maze_grid_store against a cell-array reference model.
module tb_maze_grid_store;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic       DATA_VALID;
  logic [2:0] RADIO_X;
  logic [1:0] RADIO_Y;
  logic [1:0] VALUE;
  logic       CLEAR;
  logic [2:0] READ_X;
  logic [1:0] READ_Y;
  logic [1:0] READ_VALUE;
  logic [2:0] ROBOT_X;
  logic [1:0] ROBOT_Y;
  logic [4:0] VISITED_COUNT;
  logic       UPDATE;
  logic       ERR_RANGE;
  logic       ERR_DROP;

  maze_grid_store #(.COLS(5), .ROWS(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .DATA_VALID(DATA_VALID),
    .RADIO_X(RADIO_X), .RADIO_Y(RADIO_Y), .VALUE(VALUE), .CLEAR(CLEAR),
    .READ_X(READ_X), .READ_Y(READ_Y), .READ_VALUE(READ_VALUE),
    .ROBOT_X(ROBOT_X), .ROBOT_Y(ROBOT_Y), .VISITED_COUNT(VISITED_COUNT),
    .UPDATE(UPDATE), .ERR_RANGE(ERR_RANGE), .ERR_DROP(ERR_DROP)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_bad = 0;
  int upd_seen = 0;

  // Reference model: the maze as a plain 2-D array plus the tracked status.
  int m_cell [5][4];
  int m_cnt, m_rx, m_ry, m_erng, m_edrop;
  int m_upd = 0;

  always @(negedge CLOCK) if (UPDATE === 1'b1) upd_seen++;

  function automatic void model_reset();
    for (int x = 0; x < 5; x++) for (int y = 0; y < 4; y++) m_cell[x][y] = 0;
    m_cnt = 0; m_rx = 0; m_ry = 0; m_erng = 0; m_edrop = 0;
  endfunction

  function automatic void model_packet(input int x, input int y, input int v);
    if (x >= 5 || y >= 4) begin
      m_erng = 1;
    end else if (v != 0) begin
      if (m_cell[x][y] != v) m_upd++;
      if (m_cell[x][y] == 0 && m_cnt < 20) m_cnt++;
      m_cell[x][y] = v;
      m_rx = x; m_ry = y;
    end
  endfunction

  // All tasks enter and leave 1 time unit after a rising clock edge.
  task automatic send_packet(input int x, input int y, input int v);
    RADIO_X = 3'(x); RADIO_Y = 2'(y); VALUE = 2'(v); DATA_VALID = 1'b1;
    repeat (8) @(posedge CLOCK);
    #1 DATA_VALID = 1'b0;
    repeat (4) @(posedge CLOCK);
    #1;
  endtask

  task automatic read_cell(input int x, input int y, output int v);
    READ_X = 3'(x); READ_Y = 2'(y);
    @(posedge CLOCK); #1;
    v = int'(READ_VALUE);
  endtask

  task automatic test_reset();
    int v;
    RESET = 1'b0; DATA_VALID = 1'b0; CLEAR = 1'b0;
    RADIO_X = '0; RADIO_Y = '0; VALUE = '0; READ_X = '0; READ_Y = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    model_reset();
    n_cmp++; if (READ_VALUE !== 2'd0) begin n_bad++; $display("FAIL reset_read got %0d want 0", READ_VALUE); end
    n_cmp++; if (VISITED_COUNT !== 5'd0 || ROBOT_X !== 3'd0 || ROBOT_Y !== 2'd0) begin n_bad++; $display("FAIL reset_status got cnt=%0d x=%0d y=%0d want 0", VISITED_COUNT, ROBOT_X, ROBOT_Y); end
    n_cmp++; if (UPDATE !== 1'b0 || ERR_RANGE !== 1'b0 || ERR_DROP !== 1'b0) begin n_bad++; $display("FAIL reset_flags got upd=%0b rng=%0b drop=%0b want 0", UPDATE, ERR_RANGE, ERR_DROP); end
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    read_cell(4, 3, v);
    n_cmp++; if (v != 0) begin n_bad++; $display("FAIL reset_cell got %0d want 0", v); end
  endtask

  task automatic test_basic_write();
    int v;
    send_packet(2, 1, 1); model_packet(2, 1, 1);
    read_cell(2, 1, v);
    n_cmp++; if (v != m_cell[2][1]) begin n_bad++; $display("FAIL basic_cell got %0d want %0d", v, m_cell[2][1]); end
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt) begin n_bad++; $display("FAIL basic_count got %0d want %0d", VISITED_COUNT, m_cnt); end
    n_cmp++; if (int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry) begin n_bad++; $display("FAIL basic_robot got (%0d,%0d) want (%0d,%0d)", ROBOT_X, ROBOT_Y, m_rx, m_ry); end
    n_cmp++; if (upd_seen != m_upd) begin n_bad++; $display("FAIL basic_update got %0d want %0d", upd_seen, m_upd); end
  endtask

  task automatic test_read_write_collision();
    int old_v;
    old_v = m_cell[2][1];
    READ_X = 3'd2; READ_Y = 2'd1;
    RADIO_X = 3'd2; RADIO_Y = 2'd1; VALUE = 2'd2; DATA_VALID = 1'b1;
    repeat (6) @(posedge CLOCK);
    #1;
    model_packet(2, 1, 2);
    n_cmp++; if (int'(READ_VALUE) != old_v) begin n_bad++; $display("FAIL collide_old got %0d want %0d", READ_VALUE, old_v); end
    n_cmp++; if (UPDATE !== 1'b1) begin n_bad++; $display("FAIL collide_update got %0b want 1", UPDATE); end
    @(posedge CLOCK); #1;
    n_cmp++; if (int'(READ_VALUE) != m_cell[2][1]) begin n_bad++; $display("FAIL collide_new got %0d want %0d", READ_VALUE, m_cell[2][1]); end
    n_cmp++; if (UPDATE !== 1'b0) begin n_bad++; $display("FAIL collide_pulse_width got %0b want 0", UPDATE); end
    DATA_VALID = 1'b0;
    repeat (4) @(posedge CLOCK); #1;
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt) begin n_bad++; $display("FAIL overwrite_count got %0d want %0d", VISITED_COUNT, m_cnt); end
    send_packet(2, 1, 2); model_packet(2, 1, 2);
    n_cmp++; if (upd_seen != m_upd) begin n_bad++; $display("FAIL same_value_update got %0d want %0d", upd_seen, m_upd); end
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt) begin n_bad++; $display("FAIL same_value_count got %0d want %0d", VISITED_COUNT, m_cnt); end
  endtask

  task automatic test_range_and_zero();
    int v;
    send_packet(6, 0, 1); model_packet(6, 0, 1);
    n_cmp++; if (int'(ERR_RANGE) != m_erng) begin n_bad++; $display("FAIL range_flag got %0d want %0d", ERR_RANGE, m_erng); end
    n_cmp++; if (int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry) begin n_bad++; $display("FAIL range_robot got (%0d,%0d) want (%0d,%0d)", ROBOT_X, ROBOT_Y, m_rx, m_ry); end
    read_cell(1, 0, v);
    n_cmp++; if (v != m_cell[1][0]) begin n_bad++; $display("FAIL range_alias_cell got %0d want %0d", v, m_cell[1][0]); end
    send_packet(3, 3, 0); model_packet(3, 3, 0);
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt) begin n_bad++; $display("FAIL zero_count got %0d want %0d", VISITED_COUNT, m_cnt); end
    n_cmp++; if (int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry) begin n_bad++; $display("FAIL zero_robot got (%0d,%0d) want (%0d,%0d)", ROBOT_X, ROBOT_Y, m_rx, m_ry); end
    read_cell(6, 0, v);
    n_cmp++; if (v != 0) begin n_bad++; $display("FAIL read_oob_x got %0d want 0", v); end
    read_cell(7, 3, v);
    n_cmp++; if (v != 0) begin n_bad++; $display("FAIL read_oob_xy got %0d want 0", v); end
  endtask

  task automatic test_drop();
    int v;
    RADIO_X = 3'd4; RADIO_Y = 2'd0; VALUE = 2'd3; DATA_VALID = 1'b1;
    @(posedge CLOCK); #1 DATA_VALID = 1'b0;
    @(posedge CLOCK); #1 DATA_VALID = 1'b1;
    repeat (2) @(posedge CLOCK);
    #1 RADIO_X = 3'd0; RADIO_Y = 2'd3; VALUE = 2'd2;
    repeat (6) @(posedge CLOCK);
    #1 DATA_VALID = 1'b0;
    repeat (4) @(posedge CLOCK); #1;
    model_packet(4, 0, 3);
    m_edrop = 1;
    n_cmp++; if (int'(ERR_DROP) != m_edrop) begin n_bad++; $display("FAIL drop_flag got %0d want %0d", ERR_DROP, m_edrop); end
    read_cell(4, 0, v);
    n_cmp++; if (v != m_cell[4][0]) begin n_bad++; $display("FAIL drop_first_cell got %0d want %0d", v, m_cell[4][0]); end
    read_cell(0, 3, v);
    n_cmp++; if (v != m_cell[0][3]) begin n_bad++; $display("FAIL drop_second_cell got %0d want %0d", v, m_cell[0][3]); end
    n_cmp++; if (int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry) begin n_bad++; $display("FAIL drop_robot got (%0d,%0d) want (%0d,%0d)", ROBOT_X, ROBOT_Y, m_rx, m_ry); end
  endtask

  task automatic test_random();
    int x, y, v, r;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 7)); y = int'($urandom_range(0, 3)); v = int'($urandom_range(0, 3));
      send_packet(x, y, v); model_packet(x, y, v);
      n_cmp++; if (int'(VISITED_COUNT) != m_cnt || int'(ERR_RANGE) != m_erng) begin n_bad++; $display("FAIL rand_status pkt %0d got cnt=%0d rng=%0d want cnt=%0d rng=%0d", i, VISITED_COUNT, ERR_RANGE, m_cnt, m_erng); end
      n_cmp++; if (int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry || upd_seen != m_upd) begin n_bad++; $display("FAIL rand_robot_upd pkt %0d got (%0d,%0d) upd=%0d want (%0d,%0d) upd=%0d", i, ROBOT_X, ROBOT_Y, upd_seen, m_rx, m_ry, m_upd); end
    end
    for (int cx = 0; cx < 5; cx++) for (int cy = 0; cy < 4; cy++) begin
      read_cell(cx, cy, r);
      n_cmp++; if (r != m_cell[cx][cy]) begin n_bad++; $display("FAIL rand_cell (%0d,%0d) got %0d want %0d", cx, cy, r, m_cell[cx][cy]); end
    end
  endtask

  task automatic test_fill_and_clear();
    int r;
    for (int cy = 0; cy < 4; cy++) for (int cx = 0; cx < 5; cx++) begin
      send_packet(cx, cy, 1); model_packet(cx, cy, 1);
    end
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt) begin n_bad++; $display("FAIL fill_count got %0d want %0d", VISITED_COUNT, m_cnt); end
    RADIO_X = 3'd1; RADIO_Y = 2'd1; VALUE = 2'd2; DATA_VALID = 1'b1;
    repeat (5) @(posedge CLOCK);
    #1 CLEAR = 1'b1;
    @(posedge CLOCK);
    #1 CLEAR = 1'b0;
    model_reset();
    n_cmp++; if (UPDATE !== 1'b0) begin n_bad++; $display("FAIL clear_update got %0b want 0", UPDATE); end
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt || int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry) begin n_bad++; $display("FAIL clear_status got cnt=%0d (%0d,%0d) want 0", VISITED_COUNT, ROBOT_X, ROBOT_Y); end
    n_cmp++; if (int'(ERR_RANGE) != m_erng || int'(ERR_DROP) != m_edrop) begin n_bad++; $display("FAIL clear_flags got rng=%0d drop=%0d want 0", ERR_RANGE, ERR_DROP); end
    DATA_VALID = 1'b0;
    repeat (4) @(posedge CLOCK); #1;
    n_cmp++; if (upd_seen != m_upd) begin n_bad++; $display("FAIL clear_lost_write got %0d want %0d", upd_seen, m_upd); end
    for (int cx = 0; cx < 5; cx++) for (int cy = 0; cy < 4; cy++) begin
      read_cell(cx, cy, r);
      n_cmp++; if (r != m_cell[cx][cy]) begin n_bad++; $display("FAIL clear_cell (%0d,%0d) got %0d want %0d", cx, cy, r, m_cell[cx][cy]); end
    end
  endtask

  task automatic test_reset_midway();
    int r;
    send_packet(1, 2, 3); model_packet(1, 2, 3);
    READ_X = 3'd1; READ_Y = 2'd2;
    RADIO_X = 3'd3; RADIO_Y = 2'd2; VALUE = 2'd1; DATA_VALID = 1'b1;
    repeat (4) @(posedge CLOCK);
    #1 RESET = 1'b0; DATA_VALID = 1'b0;
    #1;
    model_reset();
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt || int'(ROBOT_X) != m_rx || int'(ROBOT_Y) != m_ry) begin n_bad++; $display("FAIL midreset_status got cnt=%0d (%0d,%0d) want 0", VISITED_COUNT, ROBOT_X, ROBOT_Y); end
    n_cmp++; if (READ_VALUE !== 2'd0 || UPDATE !== 1'b0 || ERR_DROP !== 1'b0) begin n_bad++; $display("FAIL midreset_outputs got rd=%0d upd=%0b drop=%0b want 0", READ_VALUE, UPDATE, ERR_DROP); end
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b1;
    @(posedge CLOCK); #1;
    send_packet(0, 0, 3); model_packet(0, 0, 3);
    read_cell(0, 0, r);
    n_cmp++; if (r != m_cell[0][0]) begin n_bad++; $display("FAIL postreset_cell got %0d want %0d", r, m_cell[0][0]); end
    n_cmp++; if (int'(VISITED_COUNT) != m_cnt) begin n_bad++; $display("FAIL postreset_count got %0d want %0d", VISITED_COUNT, m_cnt); end
    read_cell(3, 2, r);
    n_cmp++; if (r != m_cell[3][2]) begin n_bad++; $display("FAIL inflight_discard got %0d want %0d", r, m_cell[3][2]); end
    read_cell(1, 2, r);
    n_cmp++; if (r != m_cell[1][2]) begin n_bad++; $display("FAIL reset_cleared_cell got %0d want %0d", r, m_cell[1][2]); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_read_write_collision();
    test_range_and_zero();
    test_drop();
    test_random();
    test_fill_and_clear();
    test_reset_midway();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d compares, want completion", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
